// File: rtl/bmult6x6_sched_pkg.sv
// Shared sizes and the tag carried alongside the 6x6 multiplier pipeline.
package bmult6x6_sched_pkg;
  localparam int N_REQ    = 4;
  localparam int MULT_LAT = 2;
  localparam int OP_W     = 6;
  localparam int P_W      = 12;

  typedef struct packed {
    logic                       vld;
    logic [$clog2(N_REQ)-1:0]   id;
  } tag_t;
endpackage

// File: rtl/bmult6x6_rr_sched_if.sv
// Requester/response bundle between the requesters and the shared multiplier scheduler.
interface bmult6x6_rr_sched_if #(
  parameter int N_REQ    = bmult6x6_sched_pkg::N_REQ,
  parameter int MULT_LAT = bmult6x6_sched_pkg::MULT_LAT
);
  localparam int OP_W  = bmult6x6_sched_pkg::OP_W;
  localparam int P_W   = bmult6x6_sched_pkg::P_W;
  localparam int CNT_W = $clog2(MULT_LAT + 1);

  logic                       hold;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0][OP_W-1:0] req_a;
  logic [N_REQ-1:0][OP_W-1:0] req_b;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0]           rsp_valid;
  logic [P_W-1:0]             rsp_p;
  logic [CNT_W-1:0]           inflight;
  logic [15:0]                ops_cnt;

  modport master (
    output hold, req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_p, inflight, ops_cnt
  );

  modport slave (
    input  hold, req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_p, inflight, ops_cnt
  );
endinterface

// File: rtl/Bmult6x6.sv
// Unsigned 6x6 multiplier with a LAT-deep output pipeline.
module Bmult6x6
  import bmult6x6_sched_pkg::*;
#(
  parameter int LAT = MULT_LAT
) (
  input  logic            clk,
  input  logic [OP_W-1:0] i_a,
  input  logic [OP_W-1:0] i_b,
  output logic [P_W-1:0]  o_p
);
  logic [P_W-1:0] r_p [LAT];

  // NOTE: the data stages carry no reset; validity lives in the scheduler's tag pipeline.
  always_ff @(posedge clk) begin
    r_p[0] <= P_W'(i_a) * P_W'(i_b);
    for (int s = 1; s < LAT; s++) begin
      r_p[s] <= r_p[s-1];
    end
  end

  assign o_p = r_p[LAT-1];
endmodule

// File: rtl/bmult6x6_rr_arb.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping modulo N_REQ.
module bmult6x6_rr_arb #(
  parameter int N_REQ = bmult6x6_sched_pkg::N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);
  logic            w_found;
  logic [ID_W-1:0] w_sel;

  // NOTE: every variable gets a default before the search so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sel = ID_W'((int'(ptr) + k) % N_REQ);
      if (!w_found && req[w_sel]) begin
        w_found    = 1'b1;
        gnt[w_sel] = 1'b1;
        gnt_id     = w_sel;
      end
    end
  end
endmodule

// File: rtl/bmult6x6_rr_sched.sv
// Shares one pipelined 6x6 multiplier among N_REQ requesters with round-robin issue.
module bmult6x6_rr_sched #(
  parameter int N_REQ    = bmult6x6_sched_pkg::N_REQ,
  parameter int MULT_LAT = bmult6x6_sched_pkg::MULT_LAT
) (
  input logic                clk,
  input logic                rst,
  bmult6x6_rr_sched_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MULT_LAT + 1);
  localparam int OP_W  = bmult6x6_sched_pkg::OP_W;
  localparam int P_W   = bmult6x6_sched_pkg::P_W;

  typedef bmult6x6_sched_pkg::tag_t tag_t;

  logic [ID_W-1:0]  r_ptr;
  tag_t             r_tag [MULT_LAT];
  logic [CNT_W-1:0] r_inflight;
  logic [15:0]      r_ops_cnt;

  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_issue;
  logic             w_retire;
  logic [OP_W-1:0]  w_mul_a;
  logic [OP_W-1:0]  w_mul_b;
  logic [P_W-1:0]   w_mul_p;
  tag_t             w_tag_out;

  // Reset and hold both mask requests so no grant is ever offered while either is high.
  assign w_req = (rst || bus.hold) ? '0 : bus.req_valid;

  bmult6x6_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req    (w_req),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_issue = |w_gnt;
  assign w_mul_a = w_issue ? bus.req_a[w_gnt_id] : '0;
  assign w_mul_b = w_issue ? bus.req_b[w_gnt_id] : '0;

  Bmult6x6 #(.LAT(MULT_LAT)) u_mult (
    .clk (clk),
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  assign w_tag_out = r_tag[MULT_LAT-1];
  assign w_retire  = w_tag_out.vld;

  // NOTE: all state below uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_inflight <= '0;
      r_ops_cnt  <= '0;
      for (int s = 0; s < MULT_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_ptr <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
      r_tag[0] <= '{vld: w_issue, id: w_gnt_id};
      for (int s = 1; s < MULT_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_retire);
      if (w_retire) begin
        r_ops_cnt <= r_ops_cnt + 16'd1;
      end
    end
  end

  // Outputs read as zero throughout reset, including the first reset cycle.
  always_comb begin
    bus.req_ready = w_gnt;
    bus.rsp_valid = '0;
    bus.rsp_p     = '0;
    if (w_retire && !rst) begin
      bus.rsp_valid = N_REQ'(1) << w_tag_out.id;
      bus.rsp_p     = w_mul_p;
    end
  end

  assign bus.inflight = rst ? '0 : r_inflight;
  assign bus.ops_cnt  = rst ? '0 : r_ops_cnt;
endmodule

// File: doc/bmult6x6_rr_sched.md
BMULT6X6_RR_SCHED -- requirements
Module: bmult6x6_rr_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one multiplier.
REQ-002 Parameter MULT_LAT, default 2: cycles from operands applied at Bmult6x6 inputs to P valid.
REQ-003 clk  input  1  sole clock; all state rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 hold  input  1  when high, no new grants; in-flight ops still complete.
REQ-006 req_valid  input  N_REQ  per-requester operation request.
REQ-007 req_a  input  N_REQ x 6  per-requester operand A, unsigned.
REQ-008 req_b  input  N_REQ x 6  per-requester operand B, unsigned.
REQ-009 req_ready  output  N_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i].
REQ-010 rsp_valid  output  N_REQ  one-hot result strobe, single cycle, no backpressure.
REQ-011 rsp_p  output  12  product for the strobed requester; 0 when rsp_valid all-zero.
REQ-012 inflight  output  $clog2(MULT_LAT+1)  ops issued and not yet returned.
REQ-013 ops_cnt  output  16  completed-op counter.

Function
REQ-014 At most one req_ready bit high per cycle; req_ready is combinational from req_valid, hold and the RR pointer.
REQ-015 Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
REQ-016 On handshake with requester g, ptr <= (g+1) mod N_REQ; with no handshake, ptr is unchanged.
REQ-017 With hold=1 or req_valid=0, req_ready = 0 and the multiplier inputs are driven to 0.
REQ-018 On handshake, req_a[g]/req_b[g] drive the multiplier inputs in the same cycle; one issue per cycle maximum.
REQ-019 A tag pipeline MULT_LAT deep carries {valid, id} alongside the multiplier.
REQ-020 rsp_valid[g] is high exactly MULT_LAT cycles after the handshake cycle, with rsp_p = req_a[g]*req_b[g] (full 12-bit, unsigned).
REQ-021 Sustained throughput with continuous requests is 1 op/cycle; results return in issue order.
REQ-022 Simultaneous issue and retire in the same cycle leave inflight unchanged; inflight never exceeds MULT_LAT.
REQ-023 ops_cnt increments by 1 on each cycle where rsp_valid is nonzero; it wraps from 0xFFFF to 0x0000.
REQ-024 A requester dropping req_valid without a handshake is not served, and ptr does not move.

Reset
REQ-025 While rst=1: ptr=0, tag pipeline cleared, req_ready=0, rsp_valid=0, rsp_p=0, inflight=0, ops_cnt=0.
REQ-026 Ops in flight when rst asserts are discarded; no rsp_valid is ever produced for them.
REQ-027 The first grant can occur in the first cycle with rst=0.

Structure
REQ-028 Package bmult6x6_sched_pkg holds N_REQ, MULT_LAT, OP_W=6, P_W=12, and a packed tag struct {logic vld; logic [$clog2(N_REQ)-1:0] id}.
REQ-029 The round-robin grant logic is the sub-module bmult6x6_rr_arb (inputs req, ptr; outputs one-hot gnt, gnt_id).
REQ-030 The block instantiates one Bmult6x6 and zero-gates its P output by the tag-pipeline valid bit.

Verification
REQ-031 Single op: rst released, req_valid[2]=1, a=63, b=63 at cycle 0 -> req_ready[2]=1 at cycle 0; rsp_valid=4'b0100 and rsp_p=0xF81 at cycle 2.
REQ-032 All four valid for 8 cycles with a=i+1, b=3 -> grants in order 0,1,2,3,0,1,2,3; rsp_p sequence 3,6,9,12 repeating, one result per cycle from cycle 2.
REQ-033 Requesters 1 and 3 valid, ptr=2 -> grant 3 first, then 1, then 3.
REQ-034 hold=1 with requests pending -> no req_ready; outstanding ops return normally, inflight drains to 0.
REQ-035 Issue ops at cycles 0 and 1, assert rst at cycle 1 -> no rsp_valid in any later cycle; all outputs 0 during and after reset.
REQ-036 Preload ops_cnt to 0xFFFF via 65535 ops, then one more op -> ops_cnt=0x0000; a random 10k-op run matches a reference model on order and product values.
